ecc16_scrubber: RTL

Background scrubber for the ECC-protected 16-bit configuration memory. It walks every word of the RAM, reads each 16-bit data word with its 6-bit check field, and classifies the word with the existing `ecc16_decoder`. When correction is enabled it writes single-bit corrections back, with freshly encoded parity. It sits beside the RAM, yields the RAM port to host accesses, and reports per-pass error statistics to the slow-control register space.

---
 rtl/ecc16_pkg.sv | 59 +++++
 rtl/ecc16_scrubber_if.sv | 28 ++
 rtl/ecc16_decoder.sv | 38 +++
 rtl/ecc16_encoder.sv | 17 +
 rtl/ecc16_scrubber.sv | 138 +++++++++++++
 5 files changed

// File: rtl/ecc16_pkg.sv
// Shared types and helpers for the ECC-16 scrubber slice: FSM states, error codes, code geometry.
// Latency: n/a (declarations and pure combinational functions only).
// Backpressure: n/a.
package ecc16_pkg;

    localparam int DATA_W = 16;
    localparam int PAR_W  = 6;

    // Decoder classification of one stored word.
    localparam logic [1:0] ECC_OK  = 2'd0;
    localparam logic [1:0] ECC_SBE = 2'd1;
    localparam logic [1:0] ECC_DBE = 2'd2;
    localparam logic [1:0] ECC_BAD = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_CHECK,
        S_WRITE,
        S_DONE
    } state_t;

    // Position of data bit j inside the Hamming codeword; powers of two are the check bits.
    function automatic logic [4:0] ecc16_pos(input int j);
        logic [4:0] p;
        case (j)
            0:       p = 5'd3;
            1:       p = 5'd5;
            2:       p = 5'd6;
            3:       p = 5'd7;
            4:       p = 5'd9;
            5:       p = 5'd10;
            6:       p = 5'd11;
            7:       p = 5'd12;
            8:       p = 5'd13;
            9:       p = 5'd14;
            10:      p = 5'd15;
            11:      p = 5'd17;
            12:      p = 5'd18;
            13:      p = 5'd19;
            14:      p = 5'd20;
            15:      p = 5'd21;
            default: p = 5'd0;
        endcase
        return p;
    endfunction

    // Five Hamming check bits: XOR of the codeword positions of every set data bit.
    function automatic logic [4:0] ecc16_ham(input logic [DATA_W-1:0] d);
        logic [4:0] h;
        h = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (d[j]) h = h ^ ecc16_pos(j);
        end
        return h;
    endfunction

endpackage

// File: rtl/ecc16_scrubber_if.sv
// RAM-side port bundle of the scrubber: address, read/write strobes, data and check bits, host arbitration.
// Latency: n/a (wires only); read data is expected one cycle after mem_rd.
// Backpressure: host_busy from the RAM side stalls any scrubber strobe for that cycle.
interface ecc16_scrubber_if #(
    parameter int ADDR_W = 7
);
    import ecc16_pkg::*;

    logic                host_busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [DATA_W-1:0]   mem_rdata;
    logic [PAR_W-1:0]    mem_rpar;
    logic                mem_wr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [PAR_W-1:0]    mem_wpar;

    modport master (
        input  host_busy, mem_rdata, mem_rpar,
        output mem_addr, mem_rd, mem_wr, mem_wdata, mem_wpar
    );

    modport slave (
        output host_busy, mem_rdata, mem_rpar,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_wpar
    );

endinterface

// File: rtl/ecc16_decoder.sv
// SEC-DED checker/corrector for a 16-bit word with its 6 check bits; reports clean/single/double/invalid.
// Latency: combinational.
// Backpressure: none.
module ecc16_decoder
    import ecc16_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAR_W-1:0]  par_in,
    input  logic              ecc_en,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        err_code
);

    logic [4:0] ham;
    logic [5:0] syn;

    // Syndrome = {overall parity mismatch, Hamming position}; flip the addressed data bit on a single error.
    always_comb begin
        ham      = ecc16_ham(data_in);
        syn      = {(^data_in) ^ (^par_in), par_in[4:0] ^ ham};
        data_out = data_in;
        err_code = ECC_OK;
        if (ecc_en && (syn != '0)) begin
            if (!syn[5]) begin
                err_code = ECC_DBE;
            end else if (syn[4:0] > 5'd21) begin
                err_code = ECC_BAD;
            end else begin
                // Position 0 or a power of two means a check bit flipped; data passes unchanged.
                err_code = ECC_SBE;
                for (int j = 0; j < DATA_W; j++) begin
                    if (syn[4:0] == ecc16_pos(j)) data_out[j] = ~data_in[j];
                end
            end
        end
    end

endmodule

// File: rtl/ecc16_encoder.sv
// SEC-DED check-bit generator for a 16-bit word: five Hamming bits plus an overall parity bit.
// Latency: combinational.
// Backpressure: none.
module ecc16_encoder
    import ecc16_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [PAR_W-1:0]  par_out
);

    logic [4:0] ham;

    assign ham     = ecc16_ham(data_in);
    // Top bit makes the whole 22-bit codeword even parity.
    assign par_out = {(^data_in) ^ (^ham), ham};

endmodule

// File: rtl/ecc16_scrubber.sv
// Background ECC scrubber: walks every RAM word, classifies it, optionally writes back single-bit fixes.
// Latency: 3 cycles per word (READ, CAPT, CHECK), 4 when a correction is written; +1 per host_busy stall.
// Backpressure: host_busy holds READ/WRITE with strobes low; start is ignored while a pass runs.
module ecc16_scrubber
    import ecc16_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                ecc_en,
    ecc16_scrubber_if.master    mem,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    sbe_cnt,
    output logic [CNT_W-1:0]    dbe_cnt,
    output logic                bad_valid,
    output logic [ADDR_W-1:0]   first_bad_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic                en_q;
    logic [DATA_W-1:0]   d_q;
    logic [PAR_W-1:0]    p_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   dec_data;
    logic [1:0]          dec_err;
    logic [PAR_W-1:0]    enc_par;

    // The check always runs with correction on; en_q only decides whether the fix is written back.
    ecc16_decoder u_dec (
        .data_in  (d_q),
        .par_in   (p_q),
        .ecc_en   (1'b1),
        .data_out (dec_data),
        .err_code (dec_err)
    );

    ecc16_encoder u_enc (
        .data_in (wd_q),
        .par_out (enc_par)
    );

    // Strobes decode from state so reset or host_busy drops them within the same cycle.
    assign mem.mem_addr  = addr;
    assign mem.mem_rd    = (state == S_READ)  && !mem.host_busy;
    assign mem.mem_wr    = (state == S_WRITE) && !mem.host_busy;
    assign mem.mem_wdata = wd_q;
    assign mem.mem_wpar  = enc_par;

    // Pass sequencer: one word per READ/CAPT/CHECK[/WRITE] loop, statistics updated in CHECK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            addr           <= '0;
            en_q           <= 1'b0;
            d_q            <= '0;
            p_q            <= '0;
            wd_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            sbe_cnt        <= '0;
            dbe_cnt        <= '0;
            bad_valid      <= 1'b0;
            first_bad_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr           <= '0;
                        sbe_cnt        <= '0;
                        dbe_cnt        <= '0;
                        bad_valid      <= 1'b0;
                        first_bad_addr <= '0;
                        en_q           <= ecc_en;
                        busy           <= 1'b1;
                        state          <= S_READ;
                    end
                end
                S_READ: begin
                    if (!mem.host_busy) state <= S_CAPT;
                end
                S_CAPT: begin
                    d_q   <= mem.mem_rdata;
                    p_q   <= mem.mem_rpar;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if ((dec_err != ECC_OK) && !bad_valid) begin
                        bad_valid      <= 1'b1;
                        first_bad_addr <= addr;
                    end
                    if (dec_err == ECC_SBE) begin
                        if (sbe_cnt != CNT_MAX) sbe_cnt <= sbe_cnt + 1'b1;
                    end else if (dec_err != ECC_OK) begin
                        if (dbe_cnt != CNT_MAX) dbe_cnt <= dbe_cnt + 1'b1;
                    end
                    if ((dec_err == ECC_SBE) && en_q) begin
                        // Also taken for check-bit-only errors so the stored parity gets refreshed.
                        wd_q  <= dec_data;
                        state <= S_WRITE;
                    end else if (addr == LAST_ADDR) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (!mem.host_busy) begin
                        if (addr == LAST_ADDR) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            addr  <= addr + 1'b1;
                            state <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
